// File: rtl/stream_demux_n.sv
// stream_demux_n: 1:N stream demultiplexer with one holding register per output
// channel and valid/ready flow control. A word goes to the channel picked by
// in_sel, or to every channel when in_bcast is set. Words whose select names a
// channel that does not exist are always accepted, discarded and counted in a
// saturating counter.
module stream_demux_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]          drop_cnt
);

    // One extra bit lets the range test work even when CHANNELS == 2^SEL_W.
    localparam logic [SEL_W:0] CHAN_LIMIT = (SEL_W+1)'(CHANNELS);

    logic [CHANNELS-1:0]            valid_q;
    logic [CHANNELS-1:0][WIDTH-1:0] data_q;
    logic [CNT_W-1:0]               drop_q;

    logic [CHANNELS-1:0] chan_free;
    logic [CHANNELS-1:0] sel_hit;
    logic [CHANNELS-1:0] load;
    logic                sel_in_range;
    logic                accept;
    logic                drop;

    // A channel is free when empty or when its consumer takes the word this
    // cycle; sel_hit is a one-hot decode that is all-zero for out-of-range
    // selects, so no out-of-bounds indexing is ever needed.
    always_comb begin
        chan_free = ~valid_q | out_ready;
        sel_hit   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
    end

    assign sel_in_range = ({1'b0, in_sel} < CHAN_LIMIT);

    // Broadcast needs every channel free so that no channel is ever partially
    // updated; out-of-range words are always taken so they cannot block.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &chan_free;
        end else if (sel_in_range) begin
            in_ready = |(sel_hit & chan_free);
        end
    end

    assign accept = in_valid && in_ready;
    assign load   = accept ? (in_bcast ? {CHANNELS{1'b1}} : sel_hit) : '0;
    assign drop   = accept && !in_bcast && !sel_in_range;

    // Holding registers: a load wins over a drain, so a channel streaming at
    // one word per cycle keeps valid high; a stalled word is never disturbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (load[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= in_data;
                end else if (out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Discarded-word counter sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != {CNT_W{1'b1}})) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: a 4-channel instance checked against per-channel
// expected-word queues, plus two 3-channel instances for discarded-word counting.
module tb_stream_demux_n;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;

    logic        valid_b;
    logic [1:0]  sel_b;
    logic        in_ready_b;
    logic        in_ready_c;
    logic [2:0]  out_valid_b;
    logic [2:0]  out_valid_c;
    logic [23:0] out_data_b;
    logic [23:0] out_data_c;
    logic [7:0]  drop_b;
    logic [1:0]  drop_c;

    logic [7:0]  exp_q [4][$];

    int n_vec;
    int n_err;

    stream_demux_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    stream_demux_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .in_sel(sel_b), .in_bcast(1'b0),
        .out_valid(out_valid_b), .out_ready(3'b111), .out_data(out_data_b),
        .drop_cnt(drop_b)
    );

    stream_demux_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(valid_b), .in_ready(in_ready_c), .in_data(in_data),
        .in_sel(sel_b), .in_bcast(1'b0),
        .out_valid(out_valid_c), .out_ready(3'b111), .out_data(out_data_c),
        .drop_cnt(drop_c)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle on the 4-channel instance: checks in_ready and the held
    // state against the queues before the edge, then updates the queues with
    // the handshakes that edge will perform.
    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic b,
                                 input logic [7:0] d, input logic [3:0] r);
        logic [3:0] freev;
        logic       exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_bcast  = b;
        in_data   = d;
        out_ready = r;
        #1;
        for (int k = 0; k < 4; k++) begin
            freev[k] = (exp_q[k].size() == 0) || r[k];
        end
        exp_rdy = b ? (&freev) : freev[s];
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("out_valid[%0d]", k), {31'b0, out_valid[k]},
                        {31'b0, exp_q[k].size() != 0});
            if (exp_q[k].size() != 0) begin
                checkOutput($sformatf("out_data[%0d]", k), {24'b0, out_data[k*8 +: 8]},
                            {24'b0, exp_q[k][0]});
                if (r[k]) begin
                    void'(exp_q[k].pop_front());
                end
            end
        end
        if (v && exp_rdy) begin
            for (int k = 0; k < 4; k++) begin
                if (b || (s == 2'(k))) begin
                    exp_q[k].push_back(d);
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_bcast  = 1'b0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        valid_b   = 1'b0;
        sel_b     = 2'd0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_bcast  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            valid_b   = 1'($urandom_range(0, 1));
            sel_b     = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            checkOutput("rst_out_valid", {28'b0, out_valid}, 32'h0);
            checkOutput("rst_out_data", out_data, 32'h0);
            checkOutput("rst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
            checkOutput("rst_drop_b", {24'b0, drop_b}, 32'h0);
            checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        valid_b  = 1'b0;
        rst_n    = 1'b1;

        // First word after reset lands on channel 2 only.
        applyStimulus(1'b1, 2'd2, 1'b0, 8'hA5, 4'b0000);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        checkOutput("a5_out_valid", {28'b0, out_valid}, 32'h4);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

        // Backpressure on channel 1, then replace-on-drain.
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h11, 4'b1101);
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h22, 4'b1101);
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h22, 4'b1101);
        applyStimulus(1'b1, 2'd1, 1'b0, 8'h22, 4'b1111);
        applyStimulus(1'b0, 2'd1, 1'b0, 8'h00, 4'b0000);
        applyStimulus(1'b0, 2'd1, 1'b0, 8'h00, 4'b1111);

        // Back-to-back streaming across all channels.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'(i % 4), 1'b0, 8'(i), 4'b1111);
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

        // Broadcast blocked by a stalled channel 3, then released.
        applyStimulus(1'b1, 2'd3, 1'b0, 8'h33, 4'b0111);
        applyStimulus(1'b1, 2'd0, 1'b1, 8'h5A, 4'b0111);
        applyStimulus(1'b1, 2'd0, 1'b1, 8'h5A, 4'b0111);
        applyStimulus(1'b1, 2'd0, 1'b1, 8'h5A, 4'b1111);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        checkOutput("bcast_out_data", out_data, 32'h5A5A5A5A);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

        // Random traffic mixing stalls, unicast and broadcast.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0), 8'($urandom), 4'($urandom));
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        checkOutput("main_drop_cnt", {24'b0, drop_cnt}, 32'h0);

        // Out-of-range select on the 3-channel instances.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_b = 1'b1;
            sel_b   = 2'd3;
            in_data = 8'($urandom);
            #1;
            checkOutput("oor_in_ready_b", {31'b0, in_ready_b}, 32'h1);
            checkOutput("oor_in_ready_c", {31'b0, in_ready_c}, 32'h1);
            @(posedge clk);
            #1;
            checkOutput("oor_drop_b", {24'b0, drop_b}, 32'(i + 1));
            checkOutput("oor_drop_c", {30'b0, drop_c}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            checkOutput("oor_out_valid_b", {29'b0, out_valid_b}, 32'h0);
        end
        @(negedge clk);
        valid_b = 1'b0;

        // Asynchronous reset between edges while channels 0 and 2 are full.
        applyStimulus(1'b1, 2'd0, 1'b0, 8'hC0, 4'b0000);
        applyStimulus(1'b1, 2'd2, 1'b0, 8'hC2, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("pre_areset_valid", {28'b0, out_valid}, 32'h5);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("areset_out_data", out_data, 32'h0);
        checkOutput("areset_drop_b", {24'b0, drop_b}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 1'b0, 8'h77, 4'b0000);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        applyStimulus(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
